// File: rtl/lsq_param.sv
// lsq_param: in-order load/store queue (circular buffer, tail/issue/head).
// Allocates core requests, issues them to memory in program order,
// collects load responses and retires entries in order to the core.
// Ports: clk, rst (async, active high); memR/memW + *_in_C core request;
// *_out_C + ready_out_C retired load; stall_out_C queue full; empty;
// *_out_M + valid_out_M memory request, stall_in_M back-pressure;
// data_in_M/ldstID_in_M/ready_in_M memory load response.
// Option: define LSQ_FWD_EN for store-to-load forwarding at allocation.
module lsq_param #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CNTRL_W = 16,
    parameter int TAG_W   = 4,
    localparam int ID_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memR,
    input  logic               memW,
    input  logic [ADDR_W-1:0]  addr_in_C,
    input  logic [DATA_W-1:0]  data_in_C,
    input  logic [CNTRL_W-1:0] cntrl_in_C,
    input  logic [TAG_W-1:0]   Z_in_C,
    output logic [ADDR_W-1:0]  addr_out_C,
    output logic [DATA_W-1:0]  data_out_C,
    output logic [CNTRL_W-1:0] cntrl_out_C,
    output logic [TAG_W-1:0]   Z_out_C,
    output logic               ready_out_C,
    output logic               stall_out_C,
    output logic [ADDR_W-1:0]  addr_out_M,
    output logic [DATA_W-1:0]  data_out_M,
    output logic               rw_out_M,
    output logic [ID_W-1:0]    ldstID_out_M,
    output logic               valid_out_M,
    input  logic               stall_in_M,
    input  logic [DATA_W-1:0]  data_in_M,
    input  logic [ID_W-1:0]    ldstID_in_M,
    input  logic               ready_in_M,
    output logic               empty
);

    // Per-entry status; iss_q = entry has passed the issue pointer.
    logic [DEPTH-1:0]   valid_q, done_q, iss_q, st_q;
    logic [ADDR_W-1:0]  addr_q  [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [CNTRL_W-1:0] cntrl_q [DEPTH];
    logic [TAG_W-1:0]   z_q     [DEPTH];

    logic [ID_W-1:0] tail_q, tail_d, issue_q, issue_d, head_q, head_d;
    logic [ID_W:0]   count_q, count_d;

    logic [ADDR_W-1:0]  addr_c_q;
    logic [DATA_W-1:0]  data_c_q;
    logic [CNTRL_W-1:0] cntrl_c_q;
    logic [TAG_W-1:0]   z_c_q;
    logic               ready_c_q;

    logic              alloc, fire, skip, resp, retire;
    logic              fwd_load;
    logic [DATA_W-1:0] fwd_data;

    assign stall_out_C  = (count_q == (ID_W+1)'(DEPTH));
    assign empty        = (count_q == '0);
    assign valid_out_M  = valid_q[issue_q] & ~iss_q[issue_q] & ~done_q[issue_q];
    assign ldstID_out_M = issue_q;
    assign addr_out_M   = addr_q[issue_q];
    assign data_out_M   = data_q[issue_q];
    assign rw_out_M     = st_q[issue_q];

    assign addr_out_C  = addr_c_q;
    assign data_out_C  = data_c_q;
    assign cntrl_out_C = cntrl_c_q;
    assign Z_out_C     = z_c_q;
    assign ready_out_C = ready_c_q;

    always_comb begin
        alloc  = (memR | memW) & ~stall_out_C;
        fire   = valid_out_M & ~stall_in_M;
        // A forwarded load is done before it reaches the issue pointer;
        // the pointer steps over it without a memory request.
        skip   = valid_q[issue_q] & ~iss_q[issue_q] & done_q[issue_q];
        resp   = ready_in_M & valid_q[ldstID_in_M] & iss_q[ldstID_in_M]
               & ~done_q[ldstID_in_M] & ~st_q[ldstID_in_M];
        retire = valid_q[head_q] & done_q[head_q];
        fwd_load = 1'b0;
        fwd_data = '0;
`ifdef LSQ_FWD_EN
        // Walk oldest to youngest so the last match is the youngest store.
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[head_q + ID_W'(k)] && st_q[head_q + ID_W'(k)] &&
                addr_q[head_q + ID_W'(k)] == addr_in_C) begin
                fwd_load = alloc & ~memW;
                fwd_data = data_q[head_q + ID_W'(k)];
            end
        end
`endif
        tail_d  = tail_q + ID_W'(alloc);
        issue_d = issue_q + ID_W'(fire | skip);
        head_d  = head_q + ID_W'(retire);
        count_d = count_q + (ID_W+1)'(alloc) - (ID_W+1)'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_q    <= '0;
            issue_q   <= '0;
            head_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            done_q    <= '0;
            iss_q     <= '0;
            st_q      <= '0;
            ready_c_q <= 1'b0;
            addr_c_q  <= '0;
            data_c_q  <= '0;
            cntrl_c_q <= '0;
            z_c_q     <= '0;
        end else begin
            ready_c_q <= 1'b0;
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                if (!st_q[head_q]) begin
                    ready_c_q <= 1'b1;
                    addr_c_q  <= addr_q[head_q];
                    data_c_q  <= data_q[head_q];
                    cntrl_c_q <= cntrl_q[head_q];
                    z_c_q     <= z_q[head_q];
                end
            end
            if (fire | skip) begin
                iss_q[issue_q] <= 1'b1;
                if (st_q[issue_q]) begin
                    done_q[issue_q] <= 1'b1;
                end
            end
            if (resp) begin
                done_q[ldstID_in_M] <= 1'b1;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= fwd_load;
                iss_q[tail_q]   <= 1'b0;
                st_q[tail_q]    <= memW;
            end
            tail_q  <= tail_d;
            issue_q <= issue_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only read behind valid bits.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q]  <= addr_in_C;
            data_q[tail_q]  <= fwd_load ? fwd_data : data_in_C;
            cntrl_q[tail_q] <= cntrl_in_C;
            z_q[tail_q]     <= Z_in_C;
        end
        if (resp) begin
            data_q[ldstID_in_M] <= data_in_M;
        end
    end

endmodule

// File: tb/tb_lsq_param.sv
// Testbench for lsq_param (DEPTH=4): queue-level reference model with a
// per-cycle compare process, plus directed scenarios with literal checks.
module tb_lsq_param;
    localparam int DEPTH = 4;
    localparam int IW = 2;

    logic        clk, rst;
    logic        memR, memW;
    logic [31:0] addr_in_C, data_in_C;
    logic [15:0] cntrl_in_C;
    logic [3:0]  Z_in_C;
    logic [31:0] addr_out_C, data_out_C;
    logic [15:0] cntrl_out_C;
    logic [3:0]  Z_out_C;
    logic        ready_out_C, stall_out_C;
    logic [31:0] addr_out_M, data_out_M;
    logic        rw_out_M;
    logic [IW-1:0] ldstID_out_M;
    logic        valid_out_M, stall_in_M;
    logic [31:0] data_in_M;
    logic [IW-1:0] ldstID_in_M;
    logic        ready_in_M, empty;

    lsq_param #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .memR(memR), .memW(memW),
        .addr_in_C(addr_in_C), .data_in_C(data_in_C),
        .cntrl_in_C(cntrl_in_C), .Z_in_C(Z_in_C),
        .addr_out_C(addr_out_C), .data_out_C(data_out_C),
        .cntrl_out_C(cntrl_out_C), .Z_out_C(Z_out_C),
        .ready_out_C(ready_out_C), .stall_out_C(stall_out_C),
        .addr_out_M(addr_out_M), .data_out_M(data_out_M),
        .rw_out_M(rw_out_M), .ldstID_out_M(ldstID_out_M),
        .valid_out_M(valid_out_M), .stall_in_M(stall_in_M),
        .data_in_M(data_in_M), .ldstID_in_M(ldstID_in_M),
        .ready_in_M(ready_in_M), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: program-ordered list of in-queue requests.
    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cntrl;
        logic [3:0]  z;
        bit          done;
    } ent_t;

    ent_t q[$];
    int hslot = 0;  // slot number of q[0]
    int iss = 0;    // entries q[0..iss-1] have passed the issue point
    bit          e_rdy = 0;
    logic [31:0] e_addr = 0, e_data = 0;
    logic [15:0] e_cntrl = 0;
    logic [3:0]  e_z = 0;

    always @(posedge clk) begin : model
        if (rst) begin
            q.delete();
            hslot = 0; iss = 0;
            e_rdy = 0; e_addr = 0; e_data = 0; e_cntrl = 0; e_z = 0;
        end else begin
            int sz;
            bit vm, fire, skip, ret, alloc, fwd;
            int rk;
            logic [31:0] fd;
            ent_t n;
            sz = q.size();
            vm = (iss < sz) && !q[iss].done;
            fire = vm && !stall_in_M;
            skip = (iss < sz) && q[iss].done;
            ret = (sz > 0) && q[0].done;
            alloc = (memR || memW) && sz < DEPTH;
            fwd = 0; fd = 0; rk = -1;
`ifdef LSQ_FWD_EN
            for (int k = 0; k < sz; k++)
                if (q[k].st && q[k].addr == addr_in_C) begin
                    fwd = 1; fd = q[k].data;
                end
`endif
            if (ready_in_M)
                for (int k = 0; k < sz && k < iss; k++)
                    if ((hslot + k) % DEPTH == int'(ldstID_in_M) &&
                        !q[k].st && !q[k].done)
                        rk = k;
            e_rdy = 0;
            if (fire && q[iss].st) q[iss].done = 1;
            if (rk >= 0) begin
                q[rk].done = 1;
                q[rk].data = data_in_M;
            end
            if (fire || skip) iss++;
            if (ret) begin
                if (!q[0].st) begin
                    e_rdy = 1; e_addr = q[0].addr; e_data = q[0].data;
                    e_cntrl = q[0].cntrl; e_z = q[0].z;
                end
                void'(q.pop_front());
                hslot = (hslot + 1) % DEPTH;
                iss--;
            end
            if (alloc) begin
                n.st = memW; n.addr = addr_in_C; n.cntrl = cntrl_in_C;
                n.z = Z_in_C;
                n.done = !memW && fwd;
                n.data = (!memW && fwd) ? fd : data_in_C;
                q.push_back(n);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        ev = (iss < q.size()) && !q[iss].done;
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("stall_out_C", 64'(stall_out_C), 64'(q.size() == DEPTH));
        chk("valid_out_M", 64'(valid_out_M), 64'(ev));
        if (ev) begin
            chk("ldstID_out_M", 64'(ldstID_out_M), 64'((hslot + iss) % DEPTH));
            chk("addr_out_M", 64'(addr_out_M), 64'(q[iss].addr));
            chk("rw_out_M", 64'(rw_out_M), 64'(q[iss].st));
            if (q[iss].st)
                chk("data_out_M", 64'(data_out_M), 64'(q[iss].data));
        end
        chk("ready_out_C", 64'(ready_out_C), 64'(e_rdy));
        chk("addr_out_C", 64'(addr_out_C), 64'(e_addr));
        chk("data_out_C", 64'(data_out_C), 64'(e_data));
        chk("cntrl_out_C", 64'(cntrl_out_C), 64'(e_cntrl));
        chk("Z_out_C", 64'(Z_out_C), 64'(e_z));
    end

    // Memory request monitor, sampled once inputs and outputs are settled.
    int wr_seen = 0;
    int rd_seen = 0;
    always @(negedge clk) begin
        #2;
        if (!rst && valid_out_M && !stall_in_M) begin
            if (rw_out_M) wr_seen++;
            else rd_seen++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [15:0] c,
                       input logic [3:0] z);
        memW = w; memR = r; addr_in_C = a; data_in_C = d;
        cntrl_in_C = c; Z_in_C = z;
    endtask

    task automatic idle();
        req(0, 0, 0, 0, 0, 0);
    endtask

    task automatic respond(input bit v, input logic [IW-1:0] id,
                           input logic [31:0] d);
        ready_in_M = v; ldstID_in_M = id; data_in_M = d;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        respond(0, 0, 0);
        tick();
        tick();
        rst = 0;
        wr_seen = 0;
        rd_seen = 0;
    endtask

    task automatic wait_rdy(input string name, input int lim);
        bit got;
        got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            tick();
            if (ready_out_C) got = 1;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; stall_in_M = 0;
        idle();
        respond(0, 0, 0);
        tick();
        tick();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_stall", 64'(stall_out_C), 64'd0);
        chk("rst_valid_M", 64'(valid_out_M), 64'd0);
        chk("rst_ready_C", 64'(ready_out_C), 64'd0);
        chk("rst_data_C", 64'(data_out_C), 64'd0);
        rst = 0;

`ifndef LSQ_FWD_EN
        // Store then load to the same address, both sent to memory.
        do_reset();
        req(1, 0, 40, 9000, 1, 0);
        tick();
        chk("sl_wr_valid", 64'(valid_out_M), 64'd1);
        chk("sl_wr_rw", 64'(rw_out_M), 64'd1);
        chk("sl_wr_id", 64'(ldstID_out_M), 64'd0);
        chk("sl_wr_addr", 64'(addr_out_M), 64'd40);
        req(0, 1, 40, 0, 3, 8);
        tick();
        idle();
        chk("sl_rd_valid", 64'(valid_out_M), 64'd1);
        chk("sl_rd_rw", 64'(rw_out_M), 64'd0);
        chk("sl_rd_id", 64'(ldstID_out_M), 64'd1);
        tick();
        chk("sl_idle_valid", 64'(valid_out_M), 64'd0);
        respond(1, 1, 9000);
        tick();
        respond(0, 0, 0);
        wait_rdy("sl_ready_timeout", 10);
        chk("sl_data_C", 64'(data_out_C), 64'd9000);
        chk("sl_Z_C", 64'(Z_out_C), 64'd8);
        chk("sl_addr_C", 64'(addr_out_C), 64'd40);
        tick();
        chk("sl_pulse_end", 64'(ready_out_C), 64'd0);
        chk("sl_empty", 64'(empty), 64'd1);
`endif

        // Bogus responses: unissued load ID and empty slot ID.
        do_reset();
        stall_in_M = 1;
        req(0, 1, 48, 0, 7, 2);
        tick();
        idle();
        tick();
        respond(1, 0, 111);
        tick();
        respond(1, 2, 222);
        tick();
        respond(0, 0, 0);
        tick();
        chk("bog_valid", 64'(valid_out_M), 64'd1);
        chk("bog_id", 64'(ldstID_out_M), 64'd0);
        chk("bog_ready", 64'(ready_out_C), 64'd0);
        chk("bog_empty", 64'(empty), 64'd0);
        stall_in_M = 0;
        tick();
        chk("bog_issued", 64'(valid_out_M), 64'd0);
        respond(1, 0, 777);
        tick();
        respond(0, 0, 0);
        wait_rdy("bog_ready_timeout", 10);
        chk("bog_data_C", 64'(data_out_C), 64'd777);
        chk("bog_Z_C", 64'(Z_out_C), 64'd2);
        chk("bog_cntrl_C", 64'(cntrl_out_C), 64'd7);

        // Full queue: four stores fill it, a fifth request is dropped.
        do_reset();
        stall_in_M = 1;
        for (int i = 0; i < 4; i++) begin
            req(1, 0, 32'(100 + i), 32'(i), 0, 0);
            tick();
        end
        idle();
        chk("full_stall", 64'(stall_out_C), 64'd1);
        req(0, 1, 99, 0, 0, 1);
        tick();
        idle();
        chk("full_stall_hold", 64'(stall_out_C), 64'd1);
        stall_in_M = 0;
        for (int i = 0; i < 20 && !empty; i++) tick();
        tick();
        chk("full_writes", 64'(wr_seen), 64'd4);
        chk("full_reads", 64'(rd_seen), 64'd0);
        chk("full_drained", 64'(empty), 64'd1);

`ifdef LSQ_FWD_EN
        // Forwarding: load takes the queued store's data, no read issued.
        do_reset();
        stall_in_M = 1;
        req(1, 0, 44, 9001, 0, 0);
        tick();
        req(0, 1, 44, 0, 4, 6);
        tick();
        idle();
        stall_in_M = 0;
        wait_rdy("fwd_ready_timeout", 20);
        chk("fwd_data_C", 64'(data_out_C), 64'd9001);
        chk("fwd_Z_C", 64'(Z_out_C), 64'd6);
        tick();
        tick();
        chk("fwd_writes", 64'(wr_seen), 64'd1);
        chk("fwd_reads", 64'(rd_seen), 64'd0);
`endif

        // Reset with three entries in flight; later response ignored.
        do_reset();
        stall_in_M = 1;
        req(1, 0, 1, 11, 0, 0);
        tick();
        req(0, 1, 2, 0, 0, 3);
        tick();
        req(0, 1, 3, 0, 0, 4);
        tick();
        idle();
        stall_in_M = 0;
        tick();
        tick();
        chk("mid_busy", 64'(empty), 64'd0);
        rst = 1;
        #1;
        chk("mid_empty_now", 64'(empty), 64'd1);
        chk("mid_valid_now", 64'(valid_out_M), 64'd0);
        tick();
        rst = 0;
        stall_in_M = 0;
        respond(1, 1, 55);
        tick();
        respond(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_ready", 64'(ready_out_C), 64'd0);
            chk("mid_still_empty", 64'(empty), 64'd1);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
